// File: rtl/bcd_sub_seq.sv
// Digit-serial packed-BCD subtractor: o = a - b - bi, one byte (two digits) per clock, LSB first.
// An optional second pass turns a negative ten's-complement result into sign plus magnitude.
module bcd_sub_seq #(
  parameter int N   = 33,
  parameter bit MAG = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld,
  input  logic [N*8-1:0] a,
  input  logic [N*8-1:0] b,
  input  logic           bi,
  output logic           busy,
  output logic           done,
  output logic [N*8-1:0] o,
  output logic           bo,
  output logic           sgn
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_NEG, S_DONE} state_t;

  state_t         state, state_nx;
  logic [N*8-1:0] a_r, b_r;
  logic [IW-1:0]  idx;
  logic           borrow;
  logic           last;
  logic           accept;
  logic [7:0]     a_sel, b_sel, o_sel;
  logic [8:0]     sub_res, neg_res;

  // Two ripple-chained BCD digit subtractors; returns {borrow_out, hi_digit, lo_digit}.
  function automatic logic [8:0] sub_byte(input logic [7:0] x, input logic [7:0] y,
                                          input logic bin);
    logic [4:0] d_lo, d_hi;
    logic [3:0] r_lo, r_hi;
    d_lo = {1'b0, x[3:0]} - {1'b0, y[3:0]} - {4'b0000, bin};
    r_lo = d_lo[4] ? (d_lo[3:0] + 4'd10) : d_lo[3:0];
    d_hi = {1'b0, x[7:4]} - {1'b0, y[7:4]} - {4'b0000, d_lo[4]};
    r_hi = d_hi[4] ? (d_hi[3:0] + 4'd10) : d_hi[3:0];
    return {d_hi[4], r_hi, r_lo};
  endfunction

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    o_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        a_sel = a_r[8*i +: 8];
        b_sel = b_r[8*i +: 8];
        o_sel = o[8*i +: 8];
      end
    end
  end

  assign last    = (idx == IW'(N - 1));
  assign sub_res = sub_byte(a_sel, b_sel, borrow);
  assign neg_res = sub_byte(8'h00, o_sel, borrow);
  assign accept  = ld && ((state == S_IDLE) || (state == S_DONE));
  assign busy    = (state == S_SUB) || (state == S_NEG);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: state_nx = ld ? S_SUB : S_IDLE;
      S_SUB:          if (last) state_nx = (MAG && sub_res[8]) ? S_NEG : S_DONE;
      S_NEG:          if (last) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      o      <= '0;
      bo     <= 1'b0;
      sgn    <= 1'b0;
    end else if (accept) begin
      a_r    <= a;
      b_r    <= b;
      borrow <= bi;
      idx    <= '0;
      o      <= '0;
      bo     <= 1'b0;
      sgn    <= 1'b0;
    end else if (state == S_SUB) begin
      for (int unsigned i = 0; i < N; i++)
        if (idx == IW'(i)) o[8*i +: 8] <= sub_res[7:0];
      if (last) begin
        bo  <= sub_res[8];
        idx <= '0;
        // Borrow chain restarts from zero for the complement pass.
        borrow <= (MAG && sub_res[8]) ? 1'b0 : sub_res[8];
      end else begin
        borrow <= sub_res[8];
        idx    <= idx + 1'b1;
      end
    end else if (state == S_NEG) begin
      for (int unsigned i = 0; i < N; i++)
        if (idx == IW'(i)) o[8*i +: 8] <= neg_res[7:0];
      if (last) begin
        borrow <= 1'b0;
        sgn    <= 1'b1;
        idx    <= '0;
      end else begin
        borrow <= neg_res[8];
        idx    <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Directed bench for bcd_sub_seq with N=2: one instance with the magnitude pass, one without.
module tb_bcd_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        bi = 1'b0;
  logic        busy1, done1, bo1, sgn1;
  logic [15:0] o1;
  logic        busy0, done0, bo0, sgn0;
  logic [15:0] o0;

  int errors = 0;
  int checks = 0;

  // results captured at the first done of each instance
  int          n1, n0, busy_cnt;
  logic [15:0] r_o1, r_o0;
  logic        r_bo1, r_bo0, r_sg1, r_sg0;

  always #5 clk = ~clk;

  bcd_sub_seq #(.N(2), .MAG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ld(ld), .a(a), .b(b), .bi(bi),
    .busy(busy1), .done(done1), .o(o1), .bo(bo1), .sgn(sgn1)
  );

  bcd_sub_seq #(.N(2), .MAG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ld(ld), .a(a), .b(b), .bi(bi),
    .busy(busy0), .done(done0), .o(o0), .bo(bo0), .sgn(sgn0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; issues ld for one edge, then waits (bounded) for both dones.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic biv);
    a = av; b = bv; bi = biv; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    n1 = 0; n0 = 0;
    busy_cnt = busy1 ? 1 : 0;
    for (int e = 1; e <= 20 && (n1 == 0 || n0 == 0); e++) begin
      @(posedge clk); #1;
      if (n1 == 0) begin
        if (busy1) busy_cnt++;
        if (done1) begin n1 = e; r_o1 = o1; r_bo1 = bo1; r_sg1 = sgn1; end
      end
      if (n0 == 0 && done0) begin n0 = e; r_o0 = o0; r_bo0 = bo0; r_sg0 = sgn0; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #12;
    check("rst_o",    {16'h0, o1}, 32'h0);
    check("rst_ctl",  {28'h0, bo1, sgn1, busy1, done1}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // simple subtract, no borrow
    run_op(16'h1234, 16'h0234, 1'b0);
    check("t1_lat",  n1, 2);
    check("t1_busy", busy_cnt, 2);
    check("t1_o",    {16'h0, r_o1}, 32'h1000);
    check("t1_bosg", {r_bo1, r_sg1}, 2'b00);
    idle(3);

    // 0 - 1: raw complement vs magnitude
    run_op(16'h0000, 16'h0001, 1'b0);
    check("t2_lat0", n0, 2);
    check("t2_o0",   {16'h0, r_o0}, 32'h9999);
    check("t2_bsg0", {r_bo0, r_sg0}, 2'b10);
    check("t2_lat1", n1, 4);
    check("t2_o1",   {16'h0, r_o1}, 32'h0001);
    check("t2_bsg1", {r_bo1, r_sg1}, 2'b11);
    idle(2);

    // 150 - 999 - 1 = -850
    run_op(16'h0150, 16'h0999, 1'b1);
    check("t3_o1",   {16'h0, r_o1}, 32'h0850);
    check("t3_bsg1", {r_bo1, r_sg1}, 2'b11);
    check("t3_o0",   {16'h0, r_o0}, 32'h9150);
    idle(2);

    // exact zero through a full borrow chain
    run_op(16'h5000, 16'h4999, 1'b1);
    check("t4_o",    {16'h0, r_o1}, 32'h0000);
    check("t4_bsg",  {r_bo1, r_sg1}, 2'b00);
    check("t4_lat",  n1, 2);
    idle(2);

    // borrow ripples across the byte boundary
    run_op(16'h1000, 16'h0001, 1'b0);
    check("t5_o",    {16'h0, r_o1}, 32'h0999);
    check("t5_bo",   {31'h0, r_bo1}, 32'h0);
    // back-to-back: ld in the DONE cycle starts immediately
    check("t6_indone", {31'h0, done1}, 32'h1);
    run_op(16'h9999, 16'h0001, 1'b0);
    check("t6_lat",  n1, 2);
    check("t6_o",    {16'h0, r_o1}, 32'h9998);
    // outputs hold after DONE
    idle(3);
    check("t6_hold", {15'h0, bo1, o1}, 32'h9998);
    idle(2);

    // ld while busy is ignored
    a = 16'h0000; b = 16'h0001; bi = 1'b0; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    n1 = 0;
    for (int e = 1; e <= 20 && n1 == 0; e++) begin
      if (e == 2) begin a = 16'h1234; b = 16'h0234; ld = 1'b1; end
      @(posedge clk); #1;
      ld = 1'b0;
      if (done1) begin n1 = e; r_o1 = o1; r_sg1 = sgn1; end
    end
    check("t7_lat",  n1, 4);
    check("t7_o",    {16'h0, r_o1}, 32'h0001);
    check("t7_sgn",  {31'h0, r_sg1}, 32'h1);
    idle(4);

    // asynchronous reset during SUB at idx=1
    a = 16'h9999; b = 16'h0001; bi = 1'b0; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    @(posedge clk); #1;
    check("t8_part", {16'h0, o1}, 32'h0098);
    check("t8_busy", {31'h0, busy1}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_rst_o",   {16'h0, o1}, 32'h0);
    check("t8_rst_ctl", {28'h0, bo1, sgn1, busy1, done1}, 32'h0);
    @(posedge clk); #1;
    check("t8_idle", {30'h0, busy1, done1}, 32'h0);
    rst_n = 1'b1;
    idle(1);
    run_op(16'h9999, 16'h0001, 1'b0);
    check("t8_lat",  n1, 2);
    check("t8_o",    {16'h0, r_o1}, 32'h9998);
    check("t8_bo",   {31'h0, r_bo1}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
